pin_ctrl: RTL and testbench
===========================

Name: pin_ctrl

Overview:
- Clocked, parametrised PIN entry and verification controller for the wallet unlock path.
- Two debounced buttons drive entry: b_dir_i increments the current digit (0..9 wrap), b_esq_i confirms it.
- First full entry after reset is stored as the PIN. Later entries are compared against it.
- Adds a retry counter, timed lockout and in-session PIN change.

Parameters:
- N_DIGITS, 4, number of PIN digits (≥1).
- MAX_TRIES, 3, consecutive wrong entries that trigger lockout (≥1).
- LOCK_CYCLES, 1024, lockout duration in clk_i cycles (≥1).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- b_dir_i  in  1  increment button, debounced, synchronous to clk_i.
- b_esq_i  in  1  confirm button, debounced, synchronous to clk_i.
- w_o  out  1  access granted.
- lock_o  out  1  lockout active.
- setup_o  out  1  PIN-definition mode active.
- digit_o  out  4  digit currently being selected (BCD 0..9).
- pos_o  out  max(1,clog2(N_DIGITS))  index of digit being entered.
- fail_cnt_o  out  clog2(MAX_TRIES+1)  consecutive failures.

Behaviour:
- Reset values:
  - state SETUP; stored PIN and entry buffer (4*N_DIGITS bits) cleared.
  - digit_o=0, pos_o=0, fail_cnt_o=0, w_o=0, lock_o=0, setup_o=1.
  - Button history registers reset to 1, so a button held through reset produces no event until released and pressed again.
- Events:
  - inc = b_dir_i & ~prev_dir; cfm = b_esq_i & ~prev_esq; prev_* register every cycle.
  - inc and cfm in the same cycle: both ignored.
- Digit select (SETUP, VERIFY):
  - inc: digit = (digit==9) ? 0 : digit+1. Visible on digit_o the cycle after the edge.
  - cfm: write digit into buffer[pos*4 +: 4]; digit←0.
    - If pos<N_DIGITS-1: pos←pos+1.
    - Else: pos←0 and end-of-entry action (below).
- States:
  - SETUP, setup_o=1: end-of-entry copies buffer to stored PIN (including the last digit) → VERIFY.
  - VERIFY: end-of-entry → CHECK.
  - CHECK: one cycle, buttons ignored; compare buffer to stored PIN.
    - Equal → GRANTED, fail_cnt←0.
    - Unequal, fail_cnt+1 < MAX_TRIES → VERIFY, fail_cnt+1.
    - Unequal, fail_cnt+1 == MAX_TRIES → LOCKED, fail_cnt←MAX_TRIES, timer←LOCK_CYCLES-1.
    - Buffer cleared on exit from CHECK.
  - GRANTED, w_o=1:
    - cfm → VERIFY (relock), w_o=0.
    - inc → SETUP (PIN change), w_o=0, digit/pos cleared. Old PIN is retained until the new entry completes.
  - LOCKED, lock_o=1: all events ignored; timer decrements each cycle. At timer==0 → VERIFY, fail_cnt←0, lock_o=0 next cycle.
- Latency:
  - Last cfm edge at clock t → CHECK after t → w_o=1 after clock t+1.
  - lock_o high for exactly LOCK_CYCLES cycles.
- Outputs are registered; no combinational path from buttons to outputs.
- Reset in any state, including mid-entry and during lockout, returns to the reset values; the stored PIN is lost.

Test Plan:
- Setup: N_DIGITS=4, MAX_TRIES=3, LOCK_CYCLES=16. Enter 1,2,3,4 (k inc pulses then cfm per digit) → setup_o falls after the 4th cfm; w_o=0, pos_o=0.
- Verify: enter 1,2,3,4 → w_o=1 exactly 2 clocks after the 4th cfm edge, fail_cnt_o=0. Then cfm → w_o=0, state VERIFY.
- Lockout: enter 1,2,3,5 three times → fail_cnt_o 1 then 2, then lock_o=1 for exactly 16 cycles; presses during lock do not change digit_o. Afterwards fail_cnt_o=0 and entering 1234 grants.
- Digit wrap and simultaneous press:
  - 10 inc pulses → digit_o returns to 0.
  - inc and cfm rising on the same cycle → digit_o and pos_o unchanged.
  - b_esq_i held high through reset release → no confirm until released and re-pressed.
- PIN change: in GRANTED, inc → setup_o=1, w_o=0. Enter 9,0,0,7 → old 1234 is then rejected (fail_cnt_o=1) and 9007 grants.
- Reset mid-operation: rst_i pulse after 2 digits in VERIFY, and again during LOCKED → all outputs at reset values, setup_o=1, lock_o=0.

Source files
------------

// File: rtl/pin_ctrl.sv
// pin_ctrl: PIN entry and verification controller for the wallet unlock path.
// Two debounced buttons step a BCD digit (b_dir_i) and confirm it (b_esq_i).
// The first complete entry after reset becomes the stored PIN. Later entries
// are checked against it, with a retry counter and a timed lockout.
module pin_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          b_dir_i,
  input  logic          b_esq_i,
  output logic          w_o,
  output logic          lock_o,
  output logic          setup_o,
  output logic [3:0]    digit_o,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] pos_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt_o
);

  localparam int PW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int BW = 4 * N_DIGITS;

  typedef enum logic [2:0] {
    S_SETUP,
    S_VERIFY,
    S_CHECK,
    S_GRANTED,
    S_LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   pin_q, pin_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [3:0]      digit_q, digit_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            prev_dir_q, prev_esq_q;
  logic            w_q, lock_q, setup_q;

  logic            inc_ev, cfm_ev;
  logic [FW-1:0]   fail_inc;

  // Rising-edge detection; a simultaneous press of both buttons is discarded.
  always_comb begin
    inc_ev   = b_dir_i & ~prev_dir_q & ~(b_esq_i & ~prev_esq_q);
    cfm_ev   = b_esq_i & ~prev_esq_q & ~(b_dir_i & ~prev_dir_q);
    fail_inc = fail_q + FW'(1);
  end

  // Next-state logic: digit selection, entry buffering, checking and lockout.
  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    buf_d   = buf_q;
    digit_d = digit_q;
    pos_d   = pos_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    case (state_q)
      S_SETUP, S_VERIFY: begin
        if (inc_ev) begin
          digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end else if (cfm_ev) begin
          buf_d[{pos_q, 2'b00} +: 4] = digit_q;
          digit_d = '0;
          if (pos_q != PW'(N_DIGITS - 1)) begin
            pos_d = pos_q + PW'(1);
          end else begin
            pos_d = '0;
            if (state_q == S_SETUP) begin
              // buf_d already holds the final digit, so the PIN is complete.
              pin_d   = buf_d;
              state_d = S_VERIFY;
            end else begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        buf_d = '0;
        if (buf_q == pin_q) begin
          state_d = S_GRANTED;
          fail_d  = '0;
        end else if (fail_inc == FW'(MAX_TRIES)) begin
          state_d = S_LOCKED;
          fail_d  = fail_inc;
          timer_d = TW'(LOCK_CYCLES - 1);
        end else begin
          state_d = S_VERIFY;
          fail_d  = fail_inc;
        end
      end
      S_GRANTED: begin
        if (cfm_ev) begin
          state_d = S_VERIFY;
        end else if (inc_ev) begin
          state_d = S_SETUP;
          digit_d = '0;
          pos_d   = '0;
        end
      end
      S_LOCKED: begin
        if (timer_q == '0) begin
          state_d = S_VERIFY;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_SETUP;
    endcase
  end

  // State register; status flags are registered from the next state so the
  // outputs have no path from the buttons.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_SETUP;
      pin_q      <= '0;
      buf_q      <= '0;
      digit_q    <= '0;
      pos_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      prev_dir_q <= 1'b1;
      prev_esq_q <= 1'b1;
      w_q        <= 1'b0;
      lock_q     <= 1'b0;
      setup_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pin_q      <= pin_d;
      buf_q      <= buf_d;
      digit_q    <= digit_d;
      pos_q      <= pos_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      prev_dir_q <= b_dir_i;
      prev_esq_q <= b_esq_i;
      w_q        <= (state_d == S_GRANTED);
      lock_q     <= (state_d == S_LOCKED);
      setup_q    <= (state_d == S_SETUP);
    end
  end

  assign w_o        = w_q;
  assign lock_o     = lock_q;
  assign setup_o    = setup_q;
  assign digit_o    = digit_q;
  assign pos_o      = pos_q;
  assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_pin_ctrl.sv
// tb_pin_ctrl: directed stimulus with hand-computed expectations, checked by a
// scoreboard monitor one time unit after each rising clock edge.
module tb_pin_ctrl;

  localparam int ND = 4;
  localparam int MT = 3;
  localparam int LC = 16;

  localparam int OC_MID   = 0;
  localparam int OC_SETUP = 1;
  localparam int OC_GRANT = 2;
  localparam int OC_WRONG = 3;
  localparam int OC_LOCK  = 4;

  logic       clk = 1'b0;
  logic       rst_i, b_dir_i, b_esq_i;
  logic       w_o, lock_o, setup_o;
  logic [3:0] digit_o;
  logic [1:0] pos_o;
  logic [1:0] fail_cnt_o;

  pin_ctrl #(.N_DIGITS(ND), .MAX_TRIES(MT), .LOCK_CYCLES(LC)) dut (
    .clk_i(clk), .rst_i(rst_i), .b_dir_i(b_dir_i), .b_esq_i(b_esq_i),
    .w_o(w_o), .lock_o(lock_o), .setup_o(setup_o), .digit_o(digit_o),
    .pos_o(pos_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    w, lock, setup, digit, pos, fail;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  // Expected post-edge output values, updated by hand in the stimulus.
  int e_w, e_lock, e_setup, e_digit, e_pos, e_fail;

  // Monitor: compares every queued expectation against the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (int'(w_o) != e.w || int'(lock_o) != e.lock || int'(setup_o) != e.setup ||
            int'(digit_o) != e.digit || int'(pos_o) != e.pos || int'(fail_cnt_o) != e.fail) begin
          failures++;
          $display("FAIL %s: got w=%0d lock=%0d setup=%0d digit=%0d pos=%0d fail=%0d want w=%0d lock=%0d setup=%0d digit=%0d pos=%0d fail=%0d",
                   e.name, w_o, lock_o, setup_o, digit_o, pos_o, fail_cnt_o,
                   e.w, e.lock, e.setup, e.digit, e.pos, e.fail);
        end
      end
    end
  end

  task automatic tick(input string name);
    exp_t e;
    e.name = name; e.w = e_w; e.lock = e_lock; e.setup = e_setup;
    e.digit = e_digit; e.pos = e_pos; e.fail = e_fail;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst_i = 1'b1;
    e_w = 0; e_lock = 0; e_setup = 1; e_digit = 0; e_pos = 0; e_fail = 0;
    tick(name);
    rst_i = 1'b0;
    tick({name, "_rel"});
  endtask

  task automatic inc_press();
    b_dir_i = 1'b1;
    e_digit = (e_digit == 9) ? 0 : e_digit + 1;
    tick("inc");
    b_dir_i = 1'b0;
    tick("inc_rel");
  endtask

  task automatic cfm_press(input int oc, input int ef);
    b_esq_i = 1'b1;
    e_digit = 0;
    if (oc == OC_MID) e_pos = e_pos + 1;
    else e_pos = 0;
    if (oc == OC_SETUP) e_setup = 0;
    tick("cfm");
    b_esq_i = 1'b0;
    case (oc)
      OC_GRANT: begin e_w = 1; e_fail = 0; end
      OC_WRONG: e_fail = ef;
      OC_LOCK:  begin e_lock = 1; e_fail = MT; end
      default: ;
    endcase
    tick((oc == OC_GRANT) ? "grant" : (oc == OC_LOCK) ? "lock_on" : "cfm_rel");
  endtask

  task automatic enter_pin(input int d0, d1, d2, d3, input int oc, input int ef);
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < d[i]; k++) inc_press();
      cfm_press((i == 3) ? oc : OC_MID, ef);
    end
  endtask

  task automatic relock();
    b_esq_i = 1'b1;
    e_w = 0;
    tick("relock");
    b_esq_i = 1'b0;
    tick("relock_rel");
  endtask

  // Lock already asserted by the lock_on tick; 15 more locked cycles with
  // button activity, then release back to VERIFY.
  task automatic ride_lockout();
    for (int i = 1; i <= LC - 1; i++) begin
      b_dir_i = i[0];
      tick("locked");
    end
    b_dir_i = 1'b0;
    e_lock = 0; e_fail = 0;
    tick("unlock");
  endtask

  initial begin
    rst_i = 1'b1; b_dir_i = 1'b0; b_esq_i = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Define PIN 1234, then verify it.
    enter_pin(1, 2, 3, 4, OC_SETUP, 0);
    enter_pin(1, 2, 3, 4, OC_GRANT, 0);
    relock();

    // Three wrong entries lead to a lockout, then the PIN still grants.
    enter_pin(1, 2, 3, 5, OC_WRONG, 1);
    enter_pin(1, 2, 3, 5, OC_WRONG, 2);
    enter_pin(1, 2, 3, 5, OC_LOCK, 0);
    ride_lockout();
    enter_pin(1, 2, 3, 4, OC_GRANT, 0);
    relock();

    // Digit wrap after ten increments.
    for (int i = 0; i < 10; i++) inc_press();
    for (int i = 0; i < 3; i++) inc_press();
    // Simultaneous press is ignored.
    b_dir_i = 1'b1; b_esq_i = 1'b1;
    tick("both");
    b_dir_i = 1'b0; b_esq_i = 1'b0;
    tick("both_rel");

    // Confirm held through reset produces no event until re-pressed.
    b_esq_i = 1'b1;
    do_reset("reset_held");
    tick("held");
    tick("held");
    b_esq_i = 1'b0;
    tick("held_rel");
    cfm_press(OC_MID, 0);
    do_reset("reset2");

    // PIN change from GRANTED.
    enter_pin(1, 2, 3, 4, OC_SETUP, 0);
    enter_pin(1, 2, 3, 4, OC_GRANT, 0);
    b_dir_i = 1'b1;
    e_w = 0; e_setup = 1;
    tick("pin_change");
    b_dir_i = 1'b0;
    tick("pin_change_rel");
    enter_pin(9, 0, 0, 7, OC_SETUP, 0);
    enter_pin(1, 2, 3, 4, OC_WRONG, 1);
    enter_pin(9, 0, 0, 7, OC_GRANT, 0);
    relock();

    // Reset mid-entry in VERIFY.
    inc_press();
    cfm_press(OC_MID, 0);
    inc_press();
    inc_press();
    cfm_press(OC_MID, 0);
    do_reset("reset_mid");

    // Reset during lockout.
    enter_pin(1, 2, 3, 4, OC_SETUP, 0);
    enter_pin(0, 0, 0, 0, OC_WRONG, 1);
    enter_pin(0, 0, 0, 0, OC_WRONG, 2);
    enter_pin(0, 0, 0, 0, OC_LOCK, 0);
    tick("locked");
    tick("locked");
    do_reset("reset_lock");
    // Stored PIN is gone: a 0000 entry defines it again.
    enter_pin(0, 0, 0, 0, OC_SETUP, 0);
    enter_pin(0, 0, 0, 0, OC_GRANT, 0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "timeout");
    end
  end

endmodule
